// File: rtl/sos_generator.sv
// Serialises one Morse "SOS" onto a single-bit line, single-shot or as a repeating beacon.
// Latency: out rises 1 cycle after start is sampled in IDLE; all outputs registered.
// Backpressure: none; start is ignored while busy and in the done cycle.
module sos_generator #(
    parameter int UNIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    output logic       out,
    output logic       busy,
    output logic       done,
    output logic [1:0] letter,
    output logic [1:0] element
);
    localparam int CW = $clog2(UNIT_CYCLES) + 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, MARK, SPACE, LGAP, WGAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cyc, cyc_n;
    logic [2:0]    units, units_n, seg_units;
    logic [1:0]    letter_n, element_n;
    logic          done_n, out_n, busy_n;
    logic          unit_end, seg_end;

    // Segment length in Morse units: cyc counts clocks inside a unit, units counts units.
    always_comb begin
        seg_units = 3'd1;
        case (state)
            MARK:    seg_units = (letter == 2'd2) ? 3'd3 : 3'd1;
            LGAP:    seg_units = 3'd3;
            WGAP:    seg_units = 3'd7;
            default: seg_units = 3'd1;
        endcase
    end

    assign unit_end = (cyc == CYC_LAST);
    assign seg_end  = unit_end && (units == seg_units - 3'd1);

    always_comb begin
        state_n   = state;
        letter_n  = letter;
        element_n = element;
        done_n    = 1'b0;
        if (unit_end) begin
            cyc_n   = '0;
            units_n = units + 3'd1;
        end else begin
            cyc_n   = cyc + CW'(1);
            units_n = units;
        end

        case (state)
            IDLE: begin
                // The done cycle itself is spent in IDLE, so start must wait one more cycle.
                if (start && !done) begin
                    state_n   = MARK;
                    letter_n  = 2'd1;
                    element_n = 2'd0;
                end
            end
            MARK: begin
                if (seg_end) begin
                    if (element != 2'd2) begin
                        state_n = SPACE;
                    end else if (letter == 2'd3) begin
                        done_n    = 1'b1;
                        letter_n  = 2'd0;
                        element_n = 2'd0;
                        state_n   = continuous ? WGAP : IDLE;
                    end else begin
                        state_n = LGAP;
                    end
                end
            end
            SPACE: begin
                if (seg_end) begin
                    element_n = element + 2'd1;
                    state_n   = MARK;
                end
            end
            LGAP: begin
                if (seg_end) begin
                    letter_n  = letter + 2'd1;
                    element_n = 2'd0;
                    state_n   = MARK;
                end
            end
            WGAP: begin
                if (seg_end) begin
                    letter_n  = 2'd1;
                    element_n = 2'd0;
                    state_n   = MARK;
                end
            end
            default: state_n = IDLE;
        endcase

        if (seg_end || state == IDLE) begin
            cyc_n   = '0;
            units_n = '0;
        end

        out_n  = (state_n == MARK);
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cyc     <= '0;
            units   <= '0;
            letter  <= 2'd0;
            element <= 2'd0;
            done    <= 1'b0;
            out     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cyc     <= cyc_n;
            units   <= units_n;
            letter  <= letter_n;
            element <= element_n;
            done    <= done_n;
            out     <= out_n;
            busy    <= busy_n;
        end
    end
endmodule
